// File: rtl/charis_isa_pkg.sv
// Shared ISA definitions for the constant loader: opcodes, instruction field
// positions, sequencer states and the constant-split classification.
package charis_isa_pkg;

    localparam logic [5:0] OPC_LI  = 6'b111000;
    localparam logic [5:0] OPC_LUI = 6'b111001;
    localparam logic [5:0] OPC_ORI = 6'b110011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RD_MSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_ONE,
        EMIT_HI,
        EMIT_LO
    } seq_state_e;

    // Which immediate form rebuilds the constant; ordered by priority.
    typedef enum logic [1:0] {
        SPLIT_LI,
        SPLIT_ORI,
        SPLIT_LUI,
        SPLIT_TWO
    } split_case_e;

    // Packs the immediate-form instruction fields into one word.
    function automatic logic [31:0] make_instr(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = '0;
        word[OPC_MSB:OPC_LSB] = opc;
        word[RS_MSB:RS_LSB]   = rs;
        word[RD_MSB:RD_LSB]   = rd;
        word[IMM_MSB:IMM_LSB] = imm;
        return word;
    endfunction

endpackage

// File: rtl/const_load_seq_if.sv
// Request/response bundle between the constant source, the loader and the
// instruction memory write port.
interface const_load_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    // Constant source / instruction consumer side.
    modport master (
        output in_valid, in_value, in_rd, out_ready,
        input  in_ready, out_valid, out_instr, out_last
    );

    // Loader side.
    modport slave (
        input  in_valid, in_value, in_rd, out_ready,
        output in_ready, out_valid, out_instr, out_last
    );

endinterface

// File: rtl/const_split_classify.sv
// Decides how a 32-bit constant is rebuilt by the decode-side immediate
// extender and splits it into upper and lower 16-bit immediates.
module const_split_classify
    import charis_isa_pkg::*;
(
    input  logic [31:0] value,
    output split_case_e split_case,
    output logic [15:0] hi_imm,
    output logic [15:0] lo_imm
);

    // Sign-extend wins over zero-fill so that small values, including zero,
    // always use li; lui alone only when the low half is empty.
    always_comb begin
        hi_imm = value[31:16];
        lo_imm = value[15:0];
        if (value[31:16] == {16{value[15]}}) begin
            split_case = SPLIT_LI;
        end else if (value[31:16] == 16'h0000) begin
            split_case = SPLIT_ORI;
        end else if (value[15:0] == 16'h0000) begin
            split_case = SPLIT_LUI;
        end else begin
            split_case = SPLIT_TWO;
        end
    end

endmodule

// File: rtl/const_load_seq.sv
// Turns a constant request into one or two immediate-form instruction words
// for a destination register, with valid/ready on both sides.
module const_load_seq
    import charis_isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    const_load_seq_if.slave  bus,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    split_case_e split_case;
    logic [15:0] hi_imm;
    logic [15:0] lo_imm;
    logic [15:0] lo_q;
    logic [4:0]  rd_q;
    logic [31:0] instr_q;
    logic        last_q;
    logic [31:0] first_word;
    logic [31:0] second_word;
    logic        accept;
    logic        fire;

    const_split_classify u_classify (
        .value      (bus.in_value),
        .split_case (split_case),
        .hi_imm     (hi_imm),
        .lo_imm     (lo_imm)
    );

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign fire          = (state_q != IDLE) && bus.out_ready;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;

    // The second word ORs the low half into the register lui just loaded.
    assign second_word = make_instr(OPC_ORI, rd_q, rd_q, lo_q);

    // First word is chosen from the live request so it can be registered at accept.
    always_comb begin
        first_word = '0;
        case (split_case)
            SPLIT_LI:  first_word = make_instr(OPC_LI,  5'd0, bus.in_rd, lo_imm);
            SPLIT_ORI: first_word = make_instr(OPC_ORI, 5'd0, bus.in_rd, lo_imm);
            default:   first_word = make_instr(OPC_LUI, 5'd0, bus.in_rd, hi_imm);
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: each emit state only advances on a consumer handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (split_case == SPLIT_TWO) ? EMIT_HI : EMIT_ONE;
                end
            end
            EMIT_ONE: if (bus.out_ready) state_d = IDLE;
            EMIT_HI:  if (bus.out_ready) state_d = EMIT_LO;
            EMIT_LO:  if (bus.out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output word and captured request; held unchanged while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q    <= '0;
            rd_q    <= '0;
            instr_q <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            lo_q    <= lo_imm;
            rd_q    <= bus.in_rd;
            instr_q <= first_word;
            last_q  <= (split_case != SPLIT_TWO);
        end else if (fire) begin
            if (state_q == EMIT_HI) begin
                instr_q <= second_word;
                last_q  <= 1'b1;
            end else begin
                last_q  <= 1'b0;
            end
        end
    end

    // Running total of words handed off; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (fire) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_const_load_seq.sv
// Bench for const_load_seq: expected words are queued as requests are made
// and compared as the loader hands them off.
module tb_const_load_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] instr_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [32:0]      sb_q[$];
    logic [CNT_W-1:0] exp_count;

    const_load_seq_if bus ();

    const_load_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference assembler: returns word count, words packed as {last, instr}.
    function automatic int model_words(input logic [31:0] v, input logic [4:0] rd,
                                       output logic [32:0] w0, output logic [32:0] w1);
        w1 = '0;
        if (v[31:15] == 17'h00000 || v[31:15] == 17'h1FFFF) begin
            w0 = {1'b1, 6'b111000, 5'd0, rd, v[15:0]};
            return 1;
        end
        if (v <= 32'h0000_FFFF) begin
            w0 = {1'b1, 6'b110011, 5'd0, rd, v[15:0]};
            return 1;
        end
        if (v[15:0] == 16'h0000) begin
            w0 = {1'b1, 6'b111001, 5'd0, rd, v[31:16]};
            return 1;
        end
        w0 = {1'b0, 6'b111001, 5'd0, rd, v[31:16]};
        w1 = {1'b1, 6'b110011, rd, rd, v[15:0]};
        return 2;
    endfunction

    // Scoreboard: every handoff is compared against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check_output("instr_count_at_handoff", 64'(instr_count), 64'(exp_count));
            if (sb_q.size() == 0) begin
                check_output("unexpected_word", {31'd0, bus.out_last, bus.out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check_output("out_word", {31'd0, bus.out_last, bus.out_instr}, 64'(sb_q.pop_front()));
            end
            exp_count = exp_count + 1'b1;
        end
    end

    // Called at posedge+1; waits for in_ready, queues expectations, issues one request.
    task automatic apply_stimulus(input logic [31:0] value, input logic [4:0] rd);
        int          waited;
        int          n;
        logic [32:0] w0;
        logic [32:0] w1;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            check_output("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        n = model_words(value, rd, w0, w1);
        sb_q.push_back(w0);
        if (n == 2) sb_q.push_back(w1);
        bus.in_valid = 1'b1;
        bus.in_value = value;
        bus.in_rd    = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_value = 'x;
        bus.in_rd    = 'x;
    endtask

    // Runs until all queued words are handed off, optionally with random stalls.
    task automatic drain(input bit random_ready);
        int waited;
        waited = 0;
        while (!(sb_q.size() == 0 && bus.in_ready) && waited < 200) begin
            if (random_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            waited++;
        end
        bus.out_ready = 1'b1;
        check_output("drain_done", 64'(bus.in_ready && sb_q.size() == 0), 64'd1);
    endtask

    initial begin
        logic [CNT_W-1:0] count_before;
        logic [31:0]      rv;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;
        exp_count     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_in_ready",    64'(bus.in_ready),  64'd1);
        check_output("reset_out_valid",   64'(bus.out_valid), 64'd0);
        check_output("reset_out_last",    64'(bus.out_last),  64'd0);
        check_output("reset_out_instr",   64'(bus.out_instr), 64'd0);
        check_output("reset_instr_count", 64'(instr_count),   64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("idle_ready_no_count", 64'(instr_count), 64'd0);

        // Directed encodings from the plan, cross-checked against literal words.
        apply_stimulus(32'h0000_0005, 5'd3);
        check_output("model_li_pos", 64'(sb_q[0]), {31'd0, 1'b1, 32'hE003_0005});
        drain(1'b0);
        check_output("count_after_first", 64'(instr_count), 64'd1);

        apply_stimulus(32'hFFFF_8000, 5'd3);
        check_output("model_li_neg", 64'(sb_q[0]), {31'd0, 1'b1, 32'hE003_8000});
        drain(1'b0);
        apply_stimulus(32'h0000_8000, 5'd3);
        check_output("model_ori", 64'(sb_q[0]), {31'd0, 1'b1, 32'hCC03_8000});
        drain(1'b0);
        apply_stimulus(32'h1234_0000, 5'd3);
        check_output("model_lui", 64'(sb_q[0]), {31'd0, 1'b1, 32'hE403_1234});
        drain(1'b0);
        apply_stimulus(32'h0000_0000, 5'd0);
        drain(1'b0);
        apply_stimulus(32'h0000_0007, 5'd0);
        drain(1'b0);

        // Full split under backpressure, with junk requests offered while busy.
        count_before  = instr_count;
        bus.out_ready = 1'b0;
        apply_stimulus(32'h1234_5678, 5'd3);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_hi_valid", 64'(bus.out_valid), 64'd1);
            check_output("stall_hi_word",  {31'd0, bus.out_last, bus.out_instr}, {31'd0, 1'b0, 32'hE403_1234});
            check_output("stall_hi_busy",  64'(bus.in_ready),  64'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_lo_word", {31'd0, bus.out_last, bus.out_instr}, {31'd0, 1'b1, 32'hCC63_5678});
            check_output("stall_lo_busy", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain(1'b0);
        check_output("split_count_plus2", 64'(instr_count), 64'(count_before + 4'd2));

        // Mixed constants with random stalls; also carries the counter past its wrap.
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = {{17{1'($urandom_range(0, 1))}}, 15'($urandom)};
                1:       rv = {16'h0000, 1'b1, 15'($urandom)};
                2:       rv = {16'($urandom_range(1, 65535)), 16'h0000};
                default: rv = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
            endcase
            apply_stimulus(rv, 5'($urandom_range(0, 31)));
            drain(1'b1);
        end
        check_output("count_after_random", 64'(instr_count), 64'(exp_count));

        // Reset while the high word is waiting; the low word must be discarded.
        bus.out_ready = 1'b0;
        apply_stimulus(32'h1234_5678, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_out_valid",   64'(bus.out_valid), 64'd0);
        check_output("midreset_in_ready",    64'(bus.in_ready),  64'd1);
        check_output("midreset_instr_count", 64'(instr_count),   64'd0);
        check_output("midreset_out_last",    64'(bus.out_last),  64'd0);
        sb_q.delete();
        exp_count = '0;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        apply_stimulus(32'h0000_0001, 5'd3);
        check_output("model_after_reset", 64'(sb_q[0]), {31'd0, 1'b1, 32'hE003_0001});
        drain(1'b0);
        check_output("count_after_reset", 64'(instr_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
